// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the register file with scoreboard.
package reg_file_sb_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;

  // MIPS register indices
  localparam int unsigned REG_V0 = 2;
  localparam int unsigned REG_A0 = 4;
  localparam int unsigned REG_RA = 31;

  // Widest busy vector popcount() accepts; callers zero-extend into it.
  localparam int unsigned POPCNT_MAX = 1024;

  function automatic int unsigned popcount(input logic [POPCNT_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPCNT_MAX; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits (set on issue, cleared on writeback) and their registered count.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_wr_en,
  input  logic [2*AW-1:0]     i_wr_id,
  input  logic                i_issue_en,
  input  logic [AW-1:0]       i_issue_id,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [AW:0]         o_pending_cnt
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [AW:0]         r_pending;

  // Issue is applied after the writeback clears so a new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned p = 0; p < 2; p++) begin
      if (i_wr_en[p]) w_busy_nxt[i_wr_id[p*AW +: AW]] = 1'b0;
    end
    if (i_issue_en && !(ZERO_REG != 0 && i_issue_id == '0)) begin
      w_busy_nxt[i_issue_id] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= (AW+1)'(popcount(POPCNT_MAX'(w_busy_nxt)));
    end
  end

  assign o_busy        = r_busy;
  assign o_pending_cnt = r_pending;

endmodule

// File: rtl/register.sv
// Single storage register with write enable and asynchronous active-low reset.
module register
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned W = DATA_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-through bypass, register taps and a scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned RD_PORTS = 2,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned TAP0_ID  = REG_V0,
  parameter  int unsigned TAP1_ID  = REG_A0,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [RD_PORTS*AW-1:0]     rd_id,
  output logic [RD_PORTS*DATA_W-1:0] rd_value,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic [1:0]                 wr_en,
  input  logic [2*AW-1:0]            wr_id,
  input  logic [2*DATA_W-1:0]        wr_value,
  input  logic                       issue_en,
  input  logic [AW-1:0]              issue_id,
  output logic [DATA_W-1:0]          tap0_value,
  output logic [DATA_W-1:0]          tap1_value,
  output logic [AW:0]                pending_cnt
);

  localparam int unsigned NSLOT = RD_PORTS + 2;

  logic [1:0]          w_wr_ok;
  logic [AW-1:0]       w_wr_id  [2];
  logic [DATA_W-1:0]   w_wr_val [2];
  logic                w_we     [NUM_REGS];
  logic [DATA_W-1:0]   w_wd     [NUM_REGS];
  logic [DATA_W-1:0]   w_q      [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;

  // Writes are gated by reset_n so bypass paths also read zero during reset.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_wr_id[p]  = wr_id[p*AW +: AW];
      w_wr_val[p] = wr_value[p*DATA_W +: DATA_W];
      w_wr_ok[p]  = wr_en[p] && reset_n && !(ZERO_REG != 0 && w_wr_id[p] == '0);
    end
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_we[i] = 1'b0;
      w_wd[i] = w_wr_val[0];
      for (int unsigned p = 0; p < 2; p++) begin
        if (w_wr_ok[p] && w_wr_id[p] == AW'(i)) begin
          w_we[i] = 1'b1;
          w_wd[i] = w_wr_val[p];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (ZERO_REG != 0 && g == 0) begin : g_zero
      assign w_q[g] = '0;
    end else begin : g_store
      register #(.W(DATA_W)) u_reg (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_we    (w_we[g]),
        .i_d     (w_wd[g]),
        .o_q     (w_q[g])
      );
    end
  end

  reg_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_sb (
    .i_clk         (clock),
    .i_rst_n       (reset_n),
    .i_wr_en       (wr_en),
    .i_wr_id       (wr_id),
    .i_issue_en    (issue_en),
    .i_issue_id    (issue_id),
    .o_busy        (w_busy),
    .o_pending_cnt (pending_cnt)
  );

  // Read ports and the two taps share one bypass path: slots RD_PORTS and RD_PORTS+1 are the taps.
  always_comb begin
    logic [AW-1:0]     v_id;
    logic [DATA_W-1:0] v_val;
    logic              v_busy;
    rd_value   = '0;
    rd_busy    = '0;
    tap0_value = '0;
    tap1_value = '0;
    for (int unsigned s = 0; s < NSLOT; s++) begin
      if (s < RD_PORTS)       v_id = rd_id[s*AW +: AW];
      else if (s == RD_PORTS) v_id = AW'(TAP0_ID);
      else                    v_id = AW'(TAP1_ID);
      v_val  = w_q[v_id];
      v_busy = w_busy[v_id];
      for (int unsigned p = 0; p < 2; p++) begin
        if (w_wr_ok[p] && w_wr_id[p] == v_id) begin
          v_val = w_wr_val[p];
          if (!(issue_en && issue_id == v_id)) v_busy = 1'b0;
        end
      end
      if (s < RD_PORTS) begin
        rd_value[s*DATA_W +: DATA_W] = v_val;
        rd_busy[s]                   = v_busy;
      end else if (s == RD_PORTS) begin
        tap0_value = v_val;
      end else begin
        tap1_value = v_val;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-style bench for reg_file_sb: stimulus queues expected outputs, a monitor compares them.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;

  logic           clock;
  logic           reset_n;
  logic [2*AW-1:0] rd_id;
  logic [2*DW-1:0] rd_value;
  logic [1:0]     rd_busy;
  logic [1:0]     wr_en;
  logic [2*AW-1:0] wr_id;
  logic [2*DW-1:0] wr_value;
  logic           issue_en;
  logic [AW-1:0]  issue_id;
  logic [DW-1:0]  tap0_value;
  logic [DW-1:0]  tap1_value;
  logic [AW:0]    pending_cnt;

  reg_file_sb #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .RD_PORTS (2),
    .ZERO_REG (1),
    .TAP0_ID  (REG_V0),
    .TAP1_ID  (REG_A0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd_id       (rd_id),
    .rd_value    (rd_value),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_id       (wr_id),
    .wr_value    (wr_value),
    .issue_en    (issue_en),
    .issue_id    (issue_id),
    .tap0_value  (tap0_value),
    .tap1_value  (tap1_value),
    .pending_cnt (pending_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [1:0]  busy;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [5:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        sample_tgl = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", n, act, want);
    end
  endtask

  // Monitor: each sample request pops one expectation and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(sample_tgl);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue_underflow: got empty required entry");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "/rd0"},  rd_value[31:0],     e.v0);
        chk({e.name, "/rd1"},  rd_value[63:32],    e.v1);
        chk({e.name, "/busy"}, 32'(rd_busy),       32'(e.busy));
        chk({e.name, "/tap0"}, tap0_value,         e.t0);
        chk({e.name, "/tap1"}, tap1_value,         e.t1);
        chk({e.name, "/pcnt"}, 32'(pending_cnt),   32'(e.pc));
      end
    end
  end

  task automatic expect_out(input string n, input logic [31:0] v0, input logic [31:0] v1,
                            input logic [1:0] b, input logic [31:0] t0, input logic [31:0] t1,
                            input logic [5:0] pc);
    exp_t e;
    e.name = n; e.v0 = v0; e.v1 = v1; e.busy = b; e.t0 = t0; e.t1 = t1; e.pc = pc;
    exp_q.push_back(e);
    sample_tgl = ~sample_tgl;
    #2;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    wr_en    = '0;
    issue_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_id = {b, a};
  endtask

  task automatic wr(input int unsigned p, input logic [4:0] id, input logic [31:0] v);
    wr_en[p]             = 1'b1;
    wr_id[p*AW +: AW]    = id;
    wr_value[p*DW +: DW] = v;
  endtask

  task automatic iss(input logic [4:0] id);
    issue_en = 1'b1;
    issue_id = id;
  endtask

  initial begin
    reset_n  = 1'b1;
    rd_id    = '0;
    wr_en    = '0;
    wr_id    = '0;
    wr_value = '0;
    issue_en = 1'b0;
    issue_id = '0;
    #1 reset_n = 1'b0;
    #1;

    // Random writes and issues under reset are discarded and never bypassed.
    for (int i = 0; i < 3; i++) begin
      wr_en    = 2'b11;
      wr_id    = 10'($urandom);
      wr_value = {$urandom, $urandom};
      issue_en = 1'b1;
      issue_id = 5'($urandom);
      rd_id    = wr_id;
      expect_out("reset_rand", 0, 0, 2'b00, 0, 0, 0);
      step();
    end

    idle();
    rd(5'd1, 5'd31);
    #1 reset_n = 1'b1;
    expect_out("release", 0, 0, 2'b00, 0, 0, 0);
    step();
    expect_out("release_clk", 0, 0, 2'b00, 0, 0, 0);

    wr(0, 5'd5, 32'h1234_5678);
    rd(5'd5, 5'd31);
    expect_out("wr5_bypass", 32'h1234_5678, 0, 2'b00, 0, 0, 0);
    step();
    idle();
    expect_out("wr5_stored", 32'h1234_5678, 0, 2'b00, 0, 0, 0);

    wr(0, 5'd7, 32'hAAAA_AAAA);
    wr(1, 5'd7, 32'h5555_5555);
    rd(5'd7, 5'd5);
    expect_out("dual_bypass", 32'h5555_5555, 32'h1234_5678, 2'b00, 0, 0, 0);
    step();
    idle();
    expect_out("dual_stored", 32'h5555_5555, 32'h1234_5678, 2'b00, 0, 0, 0);

    wr(0, 5'd0, 32'hFFFF_FFFF);
    iss(5'd0);
    rd(5'd0, 5'd0);
    expect_out("zero_bypass", 0, 0, 2'b00, 0, 0, 0);
    step();
    idle();
    expect_out("zero_stored", 0, 0, 2'b00, 0, 0, 0);

    rd(5'd3, 5'd9);
    iss(5'd3);
    expect_out("iss3_pre", 0, 0, 2'b00, 0, 0, 0);
    step();
    iss(5'd9);
    expect_out("iss3", 0, 0, 2'b01, 0, 0, 1);
    step();
    idle();
    expect_out("iss9", 0, 0, 2'b11, 0, 0, 2);

    wr(0, 5'd3, 32'h33);
    iss(5'd3);
    expect_out("wr_iss3_pre", 32'h33, 0, 2'b11, 0, 0, 2);
    step();
    idle();
    wr(0, 5'd3, 32'h44);
    expect_out("wr_iss3", 32'h44, 0, 2'b10, 0, 0, 2);
    step();
    idle();
    expect_out("wr3", 32'h44, 0, 2'b10, 0, 0, 1);

    wr(1, 5'd9, 32'h99);
    expect_out("wr9_bypass", 32'h44, 32'h99, 2'b00, 0, 0, 1);
    step();
    idle();
    expect_out("wr9", 32'h44, 32'h99, 2'b00, 0, 0, 0);

    wr(0, 5'd2, 32'd10);
    wr(1, 5'd4, 32'h40);
    rd(5'd2, 5'd4);
    expect_out("tap_bypass", 32'd10, 32'h40, 2'b00, 32'd10, 32'h40, 0);
    step();
    idle();
    iss(5'd6);
    expect_out("tap_stored", 32'd10, 32'h40, 2'b00, 32'd10, 32'h40, 0);
    step();
    idle();
    expect_out("iss6", 32'd10, 32'h40, 2'b00, 32'd10, 32'h40, 1);

    wr(0, 5'd2, 32'h1111);
    wr(1, 5'd4, 32'h2222);
    iss(5'd7);
    #1 reset_n = 1'b0;
    expect_out("reset_mid", 0, 0, 2'b00, 0, 0, 0);
    step();
    expect_out("reset_hold", 0, 0, 2'b00, 0, 0, 0);

    idle();
    reset_n = 1'b1;
    wr(0, 5'd2, 32'h77);
    expect_out("post_rst_bypass", 32'h77, 0, 2'b00, 32'h77, 0, 0);
    step();
    idle();
    expect_out("post_rst_edge", 32'h77, 0, 2'b00, 32'h77, 0, 0);

    #5;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: got %0d left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
